shift_sequencer: RTL and testbench

Multi-cycle sequencer for the CPU's shift/rotate datapath. It accepts one operation (logical left/right, arithmetic right, rotate left/right) over a start/busy/done handshake. It applies the operation to a 32-bit operand in chunks of at most STEP bit positions per clock, then returns the result with a one-cycle done pulse. It sits beside the ALU and replaces a full single-cycle barrel shifter where area matters more than latency.

---
 rtl/shift_sequencer.sv | 125 ++++++++++++
 tb/tb_shift_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer that moves at most STEP bit positions per clock.
// Optional abort port enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_sequencer #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [4:0]  amt,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [DW-1:0] work;
  logic [2:0]    op_q;
  logic [AW-1:0] rem;

  logic [AW-1:0] n_c;
  logic [AW-1:0] rem_nxt_c;
  logic [AW:0]   n_inv_c;
  logic [DW-1:0] step_c;
  logic          illegal_c;
  logic          abort_c;

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign illegal_c = (op > OP_ROR);
  assign result    = work;

  // Chunk size for this RUN cycle and the complementary rotate distance.
  always_comb begin
    n_c       = (rem < STEP_A) ? rem : STEP_A;
    rem_nxt_c = rem - n_c;
    n_inv_c   = (AW+1)'(DW) - {1'b0, n_c};
  end

  always_comb begin
    step_c = work;
    case (op_q)
      OP_SHL:  step_c = work << n_c;
      OP_SHR:  step_c = work >> n_c;
      OP_SHRA: step_c = DW'($signed(work) >>> n_c);
      OP_ROL:  step_c = (work << n_c) | (work >> n_inv_c);
      OP_ROR:  step_c = (work >> n_c) | (work << n_inv_c);
      default: step_c = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      op_q  <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= a;
            op_q <= op;
            rem  <= amt;
            busy <= 1'b1;
            // Zero-distance and illegal ops skip straight to the done pulse.
            if ((amt == '0) || illegal_c) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_c) begin
            state <= IDLE;
            rem   <= '0;
            busy  <= 1'b0;
          end else begin
            work <= step_c;
            rem  <= rem_nxt_c;
            if (rem_nxt_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: single-shot reference model plus directed vectors.
// Define SHIFT_SEQ_ABORT_EN to also exercise the abort path.
module tb_shift_sequencer;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [4:0]  amt = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  shift_sequencer #(.STEP(STEP)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .a(a),
    .amt(amt),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  // Whole-operation reference: the full shift or rotate in one go.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input int unsigned s);
    logic [63:0] d;
    d = {x, x};
    case (o)
      3'd0: return x << s;
      3'd1: return x >> s;
      3'd2: return 32'($signed(x) >>> s);
      3'd3: begin d = d << s; return d[63:32]; end
      3'd4: begin d = d >> s; return d[31:0]; end
      default: return x;
    endcase
  endfunction

  function automatic int run_cycles(input logic [2:0] o, input logic [4:0] s);
    if (o > 3'd4) return 0;
    return (int'(s) + int'(STEP) - 1) / int'(STEP);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-level model: tracks busy/done and the value result must show.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt = 0;
  int          m_k = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [4:0]  m_amt = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_k = 0; m_res = '0;
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (abort) begin
        m_busy = 1'b0;
        m_res = ref_op(m_op, m_a, (m_k * STEP < int'(m_amt)) ? m_k * STEP : int'(m_amt));
      end else begin
        m_cnt--; m_k++;
        if (m_cnt == 0) m_done = 1'b1;
      end
    end else if (start) begin
      m_op = op; m_a = a; m_amt = amt;
      m_busy = 1'b1; m_k = 0;
      m_cnt = run_cycles(op, amt);
      m_res = ref_op(op, a, int'(amt));
      m_done = (m_cnt == 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      if (!m_busy || m_done) check("result", result, m_res);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [4:0] s, input logic [31:0] er, input int el);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = x; amt = s;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; amt = 5'($urandom);
    cyc = 1;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_lat"}, 32'(cyc), 32'(el));
    check({nm, "_res"}, result, er);
  endtask

  initial begin
    int cyc;
    int seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);

    run_op("shl31",  3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 9);
    run_op("shra4",  3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 2);
    run_op("shr4",   3'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 2);
    run_op("ror4",   3'd4, 32'h0000_00F1, 5'd4,  32'h1000_000F, 2);
    run_op("rol1",   3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 2);
    run_op("rol0",   3'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1);
    run_op("ill7",   3'd7, 32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF, 1);
    run_op("ror13",  3'd4, 32'h1234_5678, 5'd13, ref_op(3'd4, 32'h1234_5678, 13), 5);
    run_op("shra31", 3'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 9);
    run_op("rol31",  3'd3, 32'h0000_0001, 5'd31, 32'h8000_0000, 9);
    run_op("shl8",   3'd0, 32'h00AB_CDEF, 5'd8,  32'hABCD_EF00, 3);
    run_op("ill5",   3'd5, 32'h0F0F_0F0F, 5'd0,  32'h0F0F_0F0F, 1);

    // start re-pulsed mid-run must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h0000_0001; amt = 5'd31;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 64) begin
      if (cyc == 3) begin
        start = 1'b1; op = 3'd1; a = 32'hFFFF_FFFF; amt = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("repulse_lat", 32'(cyc), 32'd9);
    check("repulse_res", result, 32'h8000_0000);

    // reset in the middle of a run
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'h0000_0001; amt = 5'd31;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'h0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_nodone", 32'(seen), 32'd0);

`ifdef SHIFT_SEQ_ABORT_EN
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678; amt = 5'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'h8123_4567);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_nodone", 32'(seen), 32'd0);
    run_op("after_abort", 3'd0, 32'h0000_0001, 5'd3, 32'h0000_0008, 2);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
